// File: rtl/scalar_mem_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scalar_mem_pkg : shared widths, FSM state encoding and request record     |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
package scalar_mem_pkg;

  localparam int ADDR_WIDTH = 24;
  localparam int DATA_WIDTH = 24;
  localparam int MEM_DEPTH  = 65536;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } mem_state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/scalar_mem_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scalar_mem_ctrl_if : MEM-stage request/response handshake bundle         |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
interface scalar_mem_ctrl_if #(
  parameter int ADDR_WIDTH = scalar_mem_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = scalar_mem_pkg::DATA_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface
`default_nettype wire

// File: rtl/scalar_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scalar_mem_ctrl : one-at-a-time load/store sequencer for the scalar RAM   |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module scalar_mem_ctrl #(
  parameter int ADDR_WIDTH   = scalar_mem_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH   = scalar_mem_pkg::DATA_WIDTH,
  parameter int MEM_DEPTH    = scalar_mem_pkg::MEM_DEPTH,
  parameter int READ_LATENCY = 2
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  scalar_mem_ctrl_if.slave           bus,
  output logic      [ADDR_WIDTH-1:0] ram_address,
  output logic      [DATA_WIDTH-1:0] ram_data,
  output logic                       ram_rden,
  output logic                       ram_wren,
  input  wire logic [DATA_WIDTH-1:0] ram_q
);

  import scalar_mem_pkg::*;

  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [ADDR_WIDTH:0] addr_ext_t;

  localparam cnt_t      c_cnt_last = cnt_t'(READ_LATENCY);
  localparam addr_ext_t c_depth    = addr_ext_t'(MEM_DEPTH);

  mem_state_t            state_q;
  cnt_t                  cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            cnt_q   <= '0;
            rdata_q <= '0;
            // Out-of-range requests skip the RAM entirely and answer at once.
            if ({1'b0, bus.req_addr} >= c_depth) begin
              err_q   <= 1'b1;
              state_q <= RESP;
            end else begin
              err_q   <= 1'b0;
              state_q <= bus.req_we ? WRITE : READ;
            end
          end
        end
        WRITE: begin
          state_q <= RESP;
        end
        READ: begin
          cnt_q <= cnt_q + cnt_t'(1);
          if (cnt_q == c_cnt_last) begin
            rdata_q <= ram_q;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Every output is forced quiet while reset is asserted, even before the first edge.
  assign bus.req_ready  = !rst && (state_q == IDLE);
  assign bus.resp_valid = !rst && (state_q == RESP);
  assign bus.resp_rdata = rst ? '0 : rdata_q;
  assign bus.resp_err   = !rst && err_q;

  assign ram_wren    = !rst && (state_q == WRITE);
  assign ram_rden    = !rst && (state_q == READ);
  assign ram_address = rst ? '0 : addr_q;
  assign ram_data    = rst ? '0 : wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_scalar_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_scalar_mem_ctrl : scoreboard bench with a READ_LATENCY=2 RAM model     |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_scalar_mem_ctrl;
  import scalar_mem_pkg::*;

  localparam int RL = 2;

  typedef struct {
    logic [23:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] ram_address;
  logic [23:0] ram_data;
  logic        ram_rden;
  logic        ram_wren;
  logic [23:0] ram_q;

  scalar_mem_ctrl_if #(.ADDR_WIDTH(24), .DATA_WIDTH(24)) bus ();

  scalar_mem_ctrl #(
    .ADDR_WIDTH  (24),
    .DATA_WIDTH  (24),
    .MEM_DEPTH   (65536),
    .READ_LATENCY(RL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .ram_rden   (ram_rden),
    .ram_wren   (ram_wren),
    .ram_q      (ram_q)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // RAM model: q is valid RL edges after the address is presented.
  logic [23:0] ram_mem [65536];
  logic [23:0] pipe [RL];
  bit          mem_init_done = 1'b0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 65536; i++) ram_mem[i] <= '0;
      mem_init_done <= 1'b1;
    end else if (ram_wren) begin
      ram_mem[ram_address[15:0]] <= ram_data;
    end
    pipe[0] <= ram_mem[ram_address[15:0]];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_q = pipe[RL-1];

  logic [23:0] shadow [65536];
  exp_t        sb_q[$];
  logic [47:0] wr_q[$];
  logic [23:0] rd_q[$];
  int          last_acc = 0;
  int          hs_cyc   = 0;
  int          wren_cnt = 0;

  task automatic send(input logic we, input logic [23:0] addr, input logic [23:0] wdata);
    exp_t e;
    int   k;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    k = 0;
    @(negedge clk);
    while (!bus.req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.req_ready) begin
      chk("req_accept_timeout", {31'd0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    e.acc    = cyc;
    last_acc = cyc;
    if (addr >= 24'(MEM_DEPTH)) begin
      e.err = 1'b1; e.rdata = '0; e.lat = 1;
    end else if (we) begin
      e.err = 1'b0; e.rdata = '0; e.lat = 2;
      shadow[addr[15:0]] = wdata;
      wr_q.push_back({addr, wdata});
    end else begin
      e.err = 1'b0; e.rdata = shadow[addr[15:0]]; e.lat = RL + 2;
      rd_q.push_back(addr);
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", sb_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Response side: latency on the rising cycle, hold while stalled, data at handshake.
  logic        prev_valid = 1'b0;
  logic [23:0] prev_rdata = '0;
  logic        prev_err   = 1'b0;
  int          rd_run     = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      rd_run     = 0;
    end else begin
      if (bus.resp_valid) begin
        if (sb_q.size() == 0) begin
          chk("resp_unexpected", {31'd0, bus.resp_valid}, 32'd0);
        end else begin
          if (!prev_valid) begin
            chk("resp_latency", cyc - sb_q[0].acc, sb_q[0].lat);
          end else begin
            chk("resp_hold_rdata", {8'd0, bus.resp_rdata}, {8'd0, prev_rdata});
            chk("resp_hold_err", {31'd0, bus.resp_err}, {31'd0, prev_err});
          end
          if (bus.resp_ready) begin
            chk("resp_rdata", {8'd0, bus.resp_rdata}, {8'd0, sb_q[0].rdata});
            chk("resp_err", {31'd0, bus.resp_err}, {31'd0, sb_q[0].err});
            hs_cyc = cyc;
            void'(sb_q.pop_front());
          end
        end
      end
      prev_valid = bus.resp_valid && !bus.resp_ready;
      prev_rdata = bus.resp_rdata;
      prev_err   = bus.resp_err;

      if (ram_wren) begin
        wren_cnt++;
        chk("wren_rden_exclusive", {31'd0, ram_rden}, 32'd0);
        if (wr_q.size() == 0) begin
          chk("wren_unexpected", {31'd0, ram_wren}, 32'd0);
        end else begin
          chk("wren_addr", {8'd0, ram_address}, {8'd0, wr_q[0][47:24]});
          chk("wren_data", {8'd0, ram_data}, {8'd0, wr_q[0][23:0]});
          void'(wr_q.pop_front());
        end
      end

      if (ram_rden) begin
        if (rd_q.size() == 0) chk("rden_unexpected", {31'd0, ram_rden}, 32'd0);
        else                  chk("rden_addr", {8'd0, ram_address}, {8'd0, rd_q[0]});
        rd_run++;
      end else if (rd_run != 0) begin
        chk("rden_cycles", rd_run, RL + 1);
        rd_run = 0;
        if (rd_q.size() != 0) void'(rd_q.pop_front());
      end
    end
  end

  initial begin
    mem_req_t r;
    int       wren_before;
    for (int i = 0; i < 65536; i++) shadow[i] = '0;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_ram_rden", {31'd0, ram_rden}, 32'd0);
    chk("rst_ram_wren", {31'd0, ram_wren}, 32'd0);
    chk("rst_ram_address", {8'd0, ram_address}, 32'd0);
    chk("rst_resp_rdata", {8'd0, bus.resp_rdata}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Basic store, load-back and out-of-range load.
    send(1'b1, 24'd1000, 24'habcdef);
    drain();
    send(1'b0, 24'd1000, 24'h0);
    drain();
    send(1'b0, 24'h010000, 24'h0);
    drain();

    // Boundary on either side of MEM_DEPTH.
    send(1'b1, 24'h00ffff, 24'h5a5a5a);
    send(1'b0, 24'h00ffff, 24'h0);
    send(1'b1, 24'hffffff, 24'h123456);
    send(1'b0, 24'hffffff, 24'h0);
    drain();

    // Stalled response with a second request already waiting.
    bus.resp_ready = 1'b0;
    send(1'b0, 24'd1000, 24'h0);
    fork
      send(1'b1, 24'd1003, 24'h333333);
      begin
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.resp_valid && k < 20) begin
          @(negedge clk);
          k++;
        end
        chk("s4_resp_seen", {31'd0, bus.resp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          chk("s4_valid_held", {31'd0, bus.resp_valid}, 32'd1);
          chk("s4_req_ready_low", {31'd0, bus.req_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
      end
    join
    chk("s4_accept_after_hs", last_acc, hs_cyc + 1);
    drain();

    // Back-to-back stores with req_valid held, then read both back.
    wren_before = wren_cnt;
    send(1'b1, 24'd1001, 24'h111111);
    send(1'b1, 24'd1002, 24'h222222);
    drain();
    chk("s5_wren_pulses", wren_cnt - wren_before, 32'd2);
    send(1'b0, 24'd1001, 24'h0);
    send(1'b0, 24'd1002, 24'h0);
    drain();

    // Mixed traffic with a few out-of-range addresses.
    for (int i = 0; i < 12; i++) begin
      r.we    = 1'($urandom_range(0, 1));
      r.addr  = 24'(1000 + $urandom_range(0, 7));
      r.wdata = 24'($urandom);
      if ($urandom_range(0, 4) == 0) r.addr = 24'(MEM_DEPTH + $urandom_range(0, 100));
      send(r.we, r.addr, r.wdata);
    end
    drain();

    // Reset in the second READ cycle aborts the load.
    send(1'b0, 24'd1000, 24'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb_q.delete();
    rd_q.delete();
    wr_q.delete();
    @(negedge clk);
    chk("s6_rden_in_rst", {31'd0, ram_rden}, 32'd0);
    chk("s6_req_ready_in_rst", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("s6_rden_after_rst", {31'd0, ram_rden}, 32'd0);
    chk("s6_req_ready_after_rst", {31'd0, bus.req_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("s6_no_resp", {31'd0, bus.resp_valid}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    send(1'b0, 24'd1000, 24'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
